// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the serial adder
package serial_adder_pkg;
    localparam int WIDTH_DEFAULT = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand request and result bundle between requester and serial adder
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             carry;
    logic [WIDTH-1:0] sum;
    modport master (output start, sub, cin, a, b, input busy, done, carry, sum);
    modport slave (input start, sub, cin, a, b, output busy, done, carry, sum);
endinterface

// File: rtl/full_adder_df.sv
// full_adder_df: single-bit dataflow full adder
module full_adder_df (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, one bit per clock, LSB first
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             bit_sum;
    logic             bit_cout;
    logic             last;

    assign last = cnt == CW'(WIDTH - 1);

    full_adder_df u_fa (
        .a   (op_a[cnt]),
        .b   (op_b[cnt]),
        .cin (carry),
        .sum (bit_sum),
        .cout(bit_cout)
    );

    // state register; reset aborts any operation without a done pulse
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // sequencing: start only honoured in IDLE, RUN lasts WIDTH cycles, DONE one cycle
    always_comb begin
        state_next = state;
        state_next = state == IDLE ? (bus.start ? RUN : IDLE) :
                     state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    // datapath: capture operands (b inverted and carry seeded for subtract), then shift in one result bit per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            sum   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == IDLE && bus.start) begin
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub | bus.cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            sum   <= {bit_sum, sum[WIDTH-1:1]};
            carry <= bit_cout;
            cnt   <= last ? '0 : cnt + 1'b1;
        end
    end

    assign bus.busy  = state == RUN;
    assign bus.done  = state == DONE;
    assign bus.sum   = sum;
    assign bus.carry = carry;
endmodule
